tx_lane_serializer: RTL

// - Downstream consumer of the 128-bit logphy data queue.
// - Pops one 128-bit word per valid/ready handshake and splits it into beats of NUM_LANES*LANE_W bits.
// - Drives the beats, LSB first, onto the per-lane TX datapath.
// - Honours a lane-side stall and a synchronous flush from link training.

---
 rtl/logphy_pkg.sv | 12 +
 rtl/lane_beat_mux.sv | 23 ++
 rtl/tx_lane_serializer.sv | 96 +++++++++
 3 files changed

// File: rtl/logphy_pkg.sv
// Shared definitions for the logphy datapath: flit width, flit type and beat arithmetic.
package logphy_pkg;

  localparam int unsigned FLIT_W = 128;

  typedef logic [FLIT_W-1:0] flit_t;

  function automatic int unsigned beats_per_flit(input int unsigned beat_w);
    return FLIT_W / beat_w;
  endfunction

endpackage

// File: rtl/lane_beat_mux.sv
// Combinational selector picking one BeatW-wide slice of a flit, slice 0 at the LSBs.
module lane_beat_mux
  import logphy_pkg::*;
#(
  parameter int unsigned BeatW = 32,
  parameter int unsigned Beats = 4,
  parameter int unsigned SelW  = $clog2(Beats)
) (
  input  flit_t             word_i,
  input  logic [SelW-1:0]   sel_i,
  output logic [BeatW-1:0]  beat_o
);

  always_comb begin
    beat_o = '0;
    for (int unsigned i = 0; i < Beats; i++) begin
      if (sel_i == SelW'(i)) begin
        beat_o = word_i[i*BeatW +: BeatW];
      end
    end
  end

endmodule

// File: rtl/tx_lane_serializer.sv
// Pops 128-bit words from the logphy queue and streams them LSB-first as lane-wide beats,
// with lane-side stall and a flush that discards the word in flight.
module tx_lane_serializer
  import logphy_pkg::*;
#(
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned LANE_W    = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  output logic                        deq_rdy_o,
  input  logic                        deq_valid_i,
  input  logic [FLIT_W-1:0]           data_i,
  input  logic                        lane_rdy_i,
  output logic                        lane_valid_o,
  output logic [NUM_LANES*LANE_W-1:0] lane_data_o,
  output logic                        flit_sop_o,
  output logic                        flit_eop_o,
  input  logic                        flush_i
);

  localparam int unsigned BEAT_W   = NUM_LANES * LANE_W;
  localparam int unsigned BEATS    = beats_per_flit(BEAT_W);
  localparam int unsigned BeatIdxW = $clog2(BEATS);

  if ((FLIT_W % BEAT_W) != 0 || BEATS < 2) begin : g_bad_cfg
    $error("tx_lane_serializer: BEAT_W must divide 128 into at least 2 beats");
  end

  localparam logic [BeatIdxW-1:0] LastBeat = BeatIdxW'(BEATS - 1);

  flit_t               hold_q, hold_d;
  logic [BeatIdxW-1:0] beat_q, beat_d;
  logic                busy_q, busy_d;

  logic              beat_last;
  logic              xfer;
  logic              pop;
  logic [BEAT_W-1:0] beat_slice;

  assign beat_last = (beat_q == LastBeat);
  assign xfer      = busy_q & lane_rdy_i;

  // Refill is allowed while the last beat leaves, so consecutive words stream without a gap.
  assign deq_rdy_o = ~flush_i & (~busy_q | (lane_rdy_i & beat_last));
  assign pop       = deq_rdy_o & deq_valid_i;

  always_comb begin
    hold_d = hold_q;
    beat_d = beat_q;
    busy_d = busy_q;
    if (flush_i) begin
      beat_d = '0;
      busy_d = 1'b0;
    end else if (pop) begin
      hold_d = data_i;
      beat_d = '0;
      busy_d = 1'b1;
    end else if (xfer) begin
      if (beat_last) begin
        beat_d = '0;
        busy_d = 1'b0;
      end else begin
        beat_d = beat_q + BeatIdxW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      beat_q <= '0;
      busy_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      beat_q <= beat_d;
      busy_q <= busy_d;
    end
  end

  lane_beat_mux #(
    .BeatW (BEAT_W),
    .Beats (BEATS),
    .SelW  (BeatIdxW)
  ) u_lane_beat_mux (
    .word_i (hold_q),
    .sel_i  (beat_q),
    .beat_o (beat_slice)
  );

  assign lane_valid_o = busy_q;
  assign lane_data_o  = busy_q ? beat_slice : '0;
  assign flit_sop_o   = busy_q & (beat_q == '0);
  assign flit_eop_o   = busy_q & beat_last;

endmodule
